// File: rtl/seq_pattern_controller_pkg.sv
// Shared definitions for the table-driven pattern sequencer: FSM encodings and default sizes.
package seq_pattern_controller_pkg;

    localparam int unsigned SEQ_WIDTH   = 3;
    localparam int unsigned SEQ_DEPTH   = 8;
    localparam int unsigned SEQ_DWELL_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } seq_state_e;

endpackage

// File: rtl/seq_dwell_counter.sv
// Loadable down-counter that times how long each pattern entry stays on the output.
module seq_dwell_counter
    import seq_pattern_controller_pkg::*;
#(
    parameter int unsigned DWELL_W = SEQ_DWELL_W
) (
    input  logic               clk,
    input  logic               clear,
    input  logic               load,
    input  logic               en,
    input  logic [DWELL_W-1:0] load_val,
    output logic               zero_c
);

    logic [DWELL_W-1:0] cnt_q;

    // Load has priority; counting saturates at zero.
    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (en && (cnt_q != '0)) begin
            cnt_q <= cnt_q - DWELL_W'(1);
        end
    end

    assign zero_c = (cnt_q == '0);

endmodule

// File: rtl/seq_pattern_controller.sv
// Programmable pattern sequencer: plays a small written table onto Q with per-step dwell.
// Build option SEQ_GRAY_OUT_EN: Gray-encode the selected entry before the Q register.
module seq_pattern_controller
    import seq_pattern_controller_pkg::*;
#(
    parameter  int unsigned WIDTH   = SEQ_WIDTH,
    parameter  int unsigned DEPTH   = SEQ_DEPTH,
    parameter  int unsigned DWELL_W = SEQ_DWELL_W,
    localparam int unsigned AW      = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               clear,
    input  logic               wr_en,
    input  logic [AW-1:0]      wr_addr,
    input  logic [WIDTH-1:0]   wr_data,
    input  logic [AW:0]        len,
    input  logic [DWELL_W-1:0] dwell,
    input  logic               loop,
    input  logic               start,
    input  logic               pause,
    input  logic               stop,
    output logic [WIDTH-1:0]   Q,
    output logic [AW-1:0]      step_idx,
    output logic               busy,
    output logic               done
);

    function automatic logic [WIDTH-1:0] out_enc(input logic [WIDTH-1:0] e);
`ifdef SEQ_GRAY_OUT_EN
        return e ^ (e >> 1);
`else
        return e;
`endif
    endfunction

    seq_state_e         state_q, state_d;
    logic [WIDTH-1:0]   tbl [DEPTH];
    logic [AW:0]        len_q, len_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic               loop_q, loop_d;
    logic [WIDTH-1:0]   q_d;
    logic [AW-1:0]      step_d;
    logic               busy_d, done_d;

    logic               tbl_we_c;
    logic               cnt_load_c, cnt_en_c, cnt_zero_c;
    logic [DWELL_W-1:0] cnt_val_c;
    logic               len_ok_c, last_c;
    logic [AW-1:0]      step_next_c;

    seq_dwell_counter #(.DWELL_W(DWELL_W)) u_dwell (
        .clk      (clk),
        .clear    (clear),
        .load     (cnt_load_c),
        .en       (cnt_en_c),
        .load_val (cnt_val_c),
        .zero_c   (cnt_zero_c)
    );

    assign len_ok_c    = (len != '0) && (len <= (AW+1)'(DEPTH));
    assign last_c      = (((AW+1)'(step_idx) + (AW+1)'(1)) == len_q);
    assign step_next_c = step_idx + AW'(1);

    // Next-state and output decode; the table is read before any same-edge write lands.
    always_comb begin
        state_d    = state_q;
        q_d        = Q;
        step_d     = step_idx;
        busy_d     = busy;
        done_d     = 1'b0;
        len_d      = len_q;
        dwell_d    = dwell_q;
        loop_d     = loop_q;
        tbl_we_c   = 1'b0;
        cnt_load_c = 1'b0;
        cnt_en_c   = 1'b0;
        cnt_val_c  = dwell_q;

        unique case (state_q)
            IDLE: begin
                tbl_we_c = wr_en;
                if (start && !stop && len_ok_c) begin
                    len_d      = len;
                    dwell_d    = dwell;
                    loop_d     = loop;
                    q_d        = out_enc(tbl[0]);
                    step_d     = '0;
                    cnt_load_c = 1'b1;
                    cnt_val_c  = dwell;
                    busy_d     = 1'b1;
                    state_d    = RUN;
                end
            end
            RUN, PAUSE: begin
                if (stop) begin
                    state_d = IDLE;
                    q_d     = '0;
                    step_d  = '0;
                    busy_d  = 1'b0;
                end else if (pause) begin
                    state_d = PAUSE;
                end else begin
                    // Releasing pause counts on that same edge, so a pause costs only its own cycles.
                    state_d = RUN;
                    if (!cnt_zero_c) begin
                        cnt_en_c = 1'b1;
                    end else if (!last_c) begin
                        step_d     = step_next_c;
                        q_d        = out_enc(tbl[step_next_c]);
                        cnt_load_c = 1'b1;
                    end else if (loop_q) begin
                        step_d     = '0;
                        q_d        = out_enc(tbl[0]);
                        cnt_load_c = 1'b1;
                    end else begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            state_q  <= IDLE;
            Q        <= '0;
            step_idx <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            len_q    <= '0;
            dwell_q  <= '0;
            loop_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            Q        <= q_d;
            step_idx <= step_d;
            busy     <= busy_d;
            done     <= done_d;
            len_q    <= len_d;
            dwell_q  <= dwell_d;
            loop_q   <= loop_d;
        end
    end

    // Pattern table; writable only while idle.
    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                tbl[i] <= '0;
            end
        end else if (tbl_we_c) begin
            tbl[wr_addr] <= wr_data;
        end
    end

endmodule
